// File: rtl/seg7_capture_pkg.sv
// Shared seven-segment definitions: active-low segment codes (bit0 = a .. bit6 = g)
// and the capture FSM state encoding.
package seg7_capture_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_e;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational seven-segment to hex decoder; any code outside the table
// deasserts valid_o.
module seg7_to_hex
  import seg7_capture_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output logic       valid_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    valid_o  = 1'b1;
    nibble_o = 4'h0;
    case (seg_n_i)
      SEG_0:   nibble_o = 4'h0;
      SEG_1:   nibble_o = 4'h1;
      SEG_2:   nibble_o = 4'h2;
      SEG_3:   nibble_o = 4'h3;
      SEG_4:   nibble_o = 4'h4;
      SEG_5:   nibble_o = 4'h5;
      SEG_6:   nibble_o = 4'h6;
      SEG_7:   nibble_o = 4'h7;
      SEG_8:   nibble_o = 4'h8;
      SEG_9:   nibble_o = 4'h9;
      SEG_A:   nibble_o = 4'hA;
      SEG_B:   nibble_o = 4'hB;
      SEG_C:   nibble_o = 4'hC;
      SEG_D:   nibble_o = 4'hD;
      SEG_E:   nibble_o = 4'hE;
      SEG_F:   nibble_o = 4'hF;
      default: valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Captures the multiplexed 7-segment bus back into a hex display word.
// Optional saturating error counter enabled by SEG7_CAPTURE_ERRCNT_EN.
module seg7_capture
  import seg7_capture_pkg::*;
#(
  parameter int NDIGITS    = 4,
  parameter int STABLE_CYC = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [6:0]             seg_n,
  input  logic [NDIGITS-1:0]     digit_sel_n,
  output logic [4*NDIGITS-1:0]   value,
  output logic                   frame_valid,
  output logic                   digit_err
`ifdef SEG7_CAPTURE_ERRCNT_EN
  ,
  output logic [7:0]             err_count
`endif
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [6:0]                seg_s1_q, seg_s2_q, prev_seg_q;
  logic [NDIGITS-1:0]        sel_s1_q, sel_s2_q, prev_sel_q;
  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [NDIGITS-1:0][3:0]   shadow_q, shadow_d, value_q, value_d;
  logic [NDIGITS-1:0]        mask_q, mask_d;
  logic                      frame_valid_q, frame_valid_d;
  logic                      digit_err_q, digit_err_d;
  logic                      sample_changed, sel_onehot, capture;
  logic                      dec_valid;
  logic [3:0]                dec_nibble;
  logic [IW-1:0]             dig_idx;

  // Synchronizers and previous-sample register idle at "blank, nothing selected".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_s1_q   <= SEG_BLANK;
      seg_s2_q   <= SEG_BLANK;
      prev_seg_q <= SEG_BLANK;
      sel_s1_q   <= '1;
      sel_s2_q   <= '1;
      prev_sel_q <= '1;
    end else begin
      seg_s1_q   <= seg_n;
      seg_s2_q   <= seg_s1_q;
      prev_seg_q <= seg_s2_q;
      sel_s1_q   <= digit_sel_n;
      sel_s2_q   <= sel_s1_q;
      prev_sel_q <= sel_s2_q;
    end
  end

  assign sample_changed = (seg_s2_q != prev_seg_q) || (sel_s2_q != prev_sel_q);
  assign sel_onehot     = $onehot(~sel_s2_q);

  always_comb begin
    dig_idx = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (!sel_s2_q[i]) dig_idx = IW'(i);
    end
  end

  seg7_to_hex u_dec (
    .seg_n_i  (seg_s2_q),
    .valid_o  (dec_valid),
    .nibble_o (dec_nibble)
  );

  // Capture fires on the SETTLE->DONE transition only, so a held digit is taken once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_onehot) begin
          state_d = SETTLE;
          cnt_d   = CW'(1);
        end
      end
      SETTLE: begin
        if (sample_changed) begin
          if (sel_onehot) begin
            cnt_d = CW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          if (cnt_q < CW'(STABLE_CYC)) cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(STABLE_CYC)) begin
            state_d = DONE;
            capture = 1'b1;
          end
        end
      end
      DONE: begin
        if (sample_changed) begin
          if (sel_onehot) begin
            state_d = SETTLE;
            cnt_d   = CW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Frame completion clears the mask first so a same-cycle capture keeps its bit.
  always_comb begin
    shadow_d      = shadow_q;
    mask_d        = mask_q;
    value_d       = value_q;
    frame_valid_d = 1'b0;
    digit_err_d   = 1'b0;
    if (&mask_q) begin
      value_d       = shadow_q;
      frame_valid_d = 1'b1;
      mask_d        = '0;
    end
    if (capture) begin
      if (dec_valid) begin
        shadow_d[dig_idx] = dec_nibble;
        mask_d[dig_idx]   = 1'b1;
      end else begin
        digit_err_d     = 1'b1;
        mask_d[dig_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      shadow_q      <= '0;
      mask_q        <= '0;
      value_q       <= '0;
      frame_valid_q <= 1'b0;
      digit_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      mask_q        <= mask_d;
      value_q       <= value_d;
      frame_valid_q <= frame_valid_d;
      digit_err_q   <= digit_err_d;
    end
  end

  assign value       = value_q;
  assign frame_valid = frame_valid_q;
  assign digit_err   = digit_err_q;

`ifdef SEG7_CAPTURE_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (digit_err_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_cnt_q <= '0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture (NDIGITS=4, STABLE_CYC=16) against a
// pattern-level model: a held pattern is captured iff it is held long enough.
module tb_seg7_capture;

  localparam int ND       = 4;
  localparam int LONG_MIN = 24;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [6:0]      seg_n;
  logic [ND-1:0]   digit_sel_n;
  logic [4*ND-1:0] value;
  logic            frame_valid;
  logic            digit_err;
`ifdef SEG7_CAPTURE_ERRCNT_EN
  logic [7:0]      err_count;
`endif

  seg7_capture #(.NDIGITS(ND), .STABLE_CYC(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .seg_n       (seg_n),
    .digit_sel_n (digit_sel_n),
    .value       (value),
    .frame_valid (frame_valid),
    .digit_err   (digit_err)
`ifdef SEG7_CAPTURE_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [3:0]  m_shadow [ND];
  logic [3:0]  m_mask;
  logic [15:0] m_value;
  int          m_err_total;
  int          m_err_sat;
  logic [15:0] exp_frames [$];

  // Observed DUT events
  logic [15:0] got_frames [$];
  int          err_pulses = 0;

  always @(negedge clk) begin
    if (frame_valid) begin
      got_frames.push_back(value);
      $display("frame value=%h", value);
    end
    if (digit_err) err_pulses++;
  end

  function automatic int decode(input logic [6:0] code);
    int r = -1;
    for (int k = 0; k < 16; k++) if (seg_tab[k] == code) r = k;
    return r;
  endfunction

  function automatic logic [3:0] sel_of(input int d);
    logic [3:0] s = 4'hF;
    s[d] = 1'b0;
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ND; k++) m_shadow[k] = 4'h0;
    m_mask    = 4'h0;
    m_value   = 16'h0;
    m_err_sat = 0;
    exp_frames.delete();
  endtask

  // Drive a pattern for cyc cycles (caller is at a negedge) and update the model.
  task automatic hold(input logic [6:0] code, input logic [3:0] sel, input int cyc);
    int idx = 0;
    int d;
    seg_n       = code;
    digit_sel_n = sel;
    repeat (cyc) @(negedge clk);
    if ($onehot(~sel) && cyc >= LONG_MIN) begin
      for (int k = 0; k < ND; k++) if (!sel[k]) idx = k;
      d = decode(code);
      if (d >= 0) begin
        m_shadow[idx] = d[3:0];
        m_mask[idx]   = 1'b1;
        if (m_mask == 4'hF) begin
          m_value = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
          exp_frames.push_back(m_value);
          m_mask = 4'h0;
        end
      end else begin
        m_err_total++;
        if (m_err_sat < 255) m_err_sat++;
        m_mask[idx] = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    seg_n       = 7'h7F;
    digit_sel_n = 4'hF;
    model_reset();
    m_err_total = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (value !== 16'h0) begin errors++; $display("FAIL reset_value: got %h expected 0000", value); end
    checks++;
    if (frame_valid !== 1'b0 || digit_err !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got fv=%b err=%b expected 0 0", frame_valid, digit_err);
    end
`ifdef SEG7_CAPTURE_ERRCNT_EN
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
`endif
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_frame();
    hold(seg_tab[4'h1], sel_of(3), 40);
    hold(seg_tab[4'h2], sel_of(2), 40);
    hold(seg_tab[4'hA], sel_of(1), 40);
    hold(seg_tab[4'hF], sel_of(0), 40);
    hold(7'h7F, 4'hF, 10);
    checks++;
    if (got_frames.size() != 1 || exp_frames.size() != 1) begin
      errors++; $display("FAIL frame_count: got %0d expected 1", got_frames.size());
    end
    checks++;
    if (value !== 16'h12AF) begin errors++; $display("FAIL frame_value: got %h expected 12AF", value); end
    while (got_frames.size() > 0 && exp_frames.size() > 0) begin
      logic [15:0] g = got_frames.pop_front();
      logic [15:0] e = exp_frames.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL frame_word: got %h expected %h", g, e); end
    end
    got_frames.delete(); exp_frames.delete();
  endtask

  task automatic test_glitch();
    hold(7'b0100100, sel_of(0), 10);
    hold(7'b1111001, sel_of(0), 30);
    hold(7'h7F, 4'hF, 10);
    checks++;
    if (got_frames.size() != 0) begin errors++; $display("FAIL glitch_early_frame: got %0d frames expected 0", got_frames.size()); end
    hold(seg_tab[3], sel_of(1), 30);
    hold(seg_tab[4], sel_of(2), 30);
    hold(seg_tab[5], sel_of(3), 30);
    hold(7'h7F, 4'hF, 10);
    checks++;
    if (got_frames.size() != 1) begin errors++; $display("FAIL glitch_frame_count: got %0d expected 1", got_frames.size()); end
    checks++;
    if (value !== 16'h5431) begin errors++; $display("FAIL glitch_value: got %h expected 5431", value); end
    checks++;
    if (value !== m_value) begin errors++; $display("FAIL glitch_model: got %h expected %h", value, m_value); end
    got_frames.delete(); exp_frames.delete();
  endtask

  task automatic test_blank();
    int e0 = err_pulses;
    hold(7'h7F, sel_of(2), 30);
    hold(7'h7F, 4'hF, 10);
    checks++;
    if (err_pulses - e0 != 1) begin errors++; $display("FAIL blank_err_pulses: got %0d expected 1", err_pulses - e0); end
    checks++;
    if (got_frames.size() != 0) begin errors++; $display("FAIL blank_frame: got %0d frames expected 0", got_frames.size()); end
`ifdef SEG7_CAPTURE_ERRCNT_EN
    checks++;
    if (err_count !== 8'd1 || m_err_sat != 1) begin
      errors++; $display("FAIL blank_err_count: got %0d expected 1", err_count);
    end
`endif
  endtask

  task automatic test_two_sel();
    int          e0 = err_pulses;
    logic [15:0] v0 = value;
    hold(seg_tab[7], 4'b1100, 50);
    hold(7'h7F, 4'hF, 10);
    checks++;
    if (err_pulses != e0 || got_frames.size() != 0) begin
      errors++; $display("FAIL two_sel: got err=%0d frames=%0d expected 0 0", err_pulses - e0, got_frames.size());
    end
    checks++;
    if (value !== v0) begin errors++; $display("FAIL two_sel_value: got %h expected %h", value, v0); end
  endtask

  task automatic test_reset_midframe();
    hold(seg_tab[9], sel_of(0), 30);
    hold(seg_tab[9], sel_of(1), 30);
    hold(seg_tab[9], sel_of(2), 30);
    hold(7'h7F, 4'hF, 5);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    checks++;
    if (value !== 16'h0) begin errors++; $display("FAIL midreset_value: got %h expected 0000", value); end
    hold(seg_tab[8], sel_of(3), 30);
    hold(seg_tab[0], sel_of(2), 30);
    hold(seg_tab[0], sel_of(1), 30);
    hold(seg_tab[8], sel_of(0), 30);
    hold(7'h7F, 4'hF, 10);
    checks++;
    if (got_frames.size() != 1) begin errors++; $display("FAIL midreset_frames: got %0d expected 1", got_frames.size()); end
    checks++;
    if (value !== 16'h8008) begin errors++; $display("FAIL midreset_value_after: got %h expected 8008", value); end
    got_frames.delete(); exp_frames.delete();
  endtask

  task automatic test_random();
    logic [6:0] pc = 7'h7F;
    logic [3:0] ps = 4'hF;
    int         e0 = err_pulses;
    int         me0 = m_err_total;
    for (int n = 0; n < 60; n++) begin
      logic [6:0] c;
      logic [3:0] s;
      int         cyc;
      do begin
        c = ($urandom_range(0, 3) != 0) ? seg_tab[$urandom_range(0, 15)] : 7'($urandom());
        s = ($urandom_range(0, 9) != 0) ? sel_of($urandom_range(0, 3)) : 4'b0011;
      end while (c == pc && s == ps);
      cyc = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 10) : $urandom_range(LONG_MIN, 40);
      hold(c, s, cyc);
      pc = c;
      ps = s;
    end
    hold(7'h7F, 4'hF, 10);
    checks++;
    if (err_pulses - e0 != m_err_total - me0) begin
      errors++; $display("FAIL rand_err_pulses: got %0d expected %0d", err_pulses - e0, m_err_total - me0);
    end
    checks++;
    if (got_frames.size() != exp_frames.size()) begin
      errors++; $display("FAIL rand_frame_count: got %0d expected %0d", got_frames.size(), exp_frames.size());
    end
    while (got_frames.size() > 0 && exp_frames.size() > 0) begin
      logic [15:0] g = got_frames.pop_front();
      logic [15:0] e = exp_frames.pop_front();
      checks++;
      if (g !== e) begin errors++; $display("FAIL rand_frame_word: got %h expected %h", g, e); end
    end
    checks++;
    if (value !== m_value) begin errors++; $display("FAIL rand_value: got %h expected %h", value, m_value); end
`ifdef SEG7_CAPTURE_ERRCNT_EN
    checks++;
    if (err_count !== 8'(m_err_sat)) begin errors++; $display("FAIL rand_err_count: got %0d expected %0d", err_count, m_err_sat); end
`endif
    got_frames.delete(); exp_frames.delete();
  endtask

`ifdef SEG7_CAPTURE_ERRCNT_EN
  task automatic test_saturate();
    int e0 = err_pulses;
    for (int n = 0; n < 300; n++) begin
      hold((n % 2 == 0) ? 7'h7F : 7'h55, sel_of(n % 4), LONG_MIN);
    end
    hold(7'h7F, 4'hF, 10);
    checks++;
    if (err_pulses - e0 != 300) begin errors++; $display("FAIL sat_pulses: got %0d expected 300", err_pulses - e0); end
    checks++;
    if (err_count !== 8'd255 || m_err_sat != 255) begin
      errors++; $display("FAIL sat_err_count: got %0d expected 255", err_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_glitch();
    test_blank();
    test_two_sel();
    test_reset_midframe();
    test_random();
`ifdef SEG7_CAPTURE_ERRCNT_EN
    test_saturate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
